lfsr_word_ctrl: RTL
===================

Name: lfsr_word_ctrl

Overview:
- Sequencer for the 17-bit serial LFSR. Drives the LFSR shift enable and reload, and packs its serial output into WORD_W-bit random words.
- Delivers each word over a valid/ready handshake to a downstream consumer, e.g. a test-pattern or noise source.
- Supports discarding SKIP bits before each word, and an on-demand reseed of the LFSR.

Parameters:
- WORD_W, 8, output word width in bits; legal range 1..16.
- SKIP, 0, LFSR bits shifted and discarded before each word; legal range 0..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  level; request continuous word generation.
- reseed  in  1  single-cycle pulse; reload the LFSR seed and abort the current word.
- lfsr_bit  in  1  LFSR serial output. It is the MSB the LFSR will hold after the shift in the current cycle.
- sh_en  out  1  LFSR shift enable.
- lfsr_load  out  1  one-cycle pulse; LFSR reloads its seed.
- out_data  out  WORD_W  packed random word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts the word.
- busy  out  1  high in FILL or RESEED.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, sh_en=0, lfsr_load=0, out_data=0, out_valid=0, busy=0.
  - Bit counter=0, shift register=0.
- FSM states: IDLE, FILL, HOLD, RESEED. sh_en=(state==FILL), lfsr_load=(state==RESEED), busy=(FILL|RESEED); all three are decoded combinationally from the state register.
- IDLE -> FILL on the edge where en=1, so sh_en goes high the next cycle.
- FILL: one LFSR shift per cycle for exactly SKIP+WORD_W cycles. Bit counter width is clog2(SKIP+WORD_W+1).
  - The first SKIP bits are discarded.
  - The next WORD_W bits are shifted in MSB-first: sreg <= {sreg[WORD_W-2:0], lfsr_bit}. The first kept bit ends up in out_data[WORD_W-1].
  - At the edge ending the last FILL cycle: out_data<=packed word, out_valid<=1, counter<=0, FILL -> HOLD.
  - Latency: en sampled at edge k gives out_valid high from cycle k+SKIP+WORD_W+1.
- HOLD: sh_en=0; out_data is stable while out_valid=1.
  - On out_valid & out_ready, out_valid<=0 at that edge.
  - Next state is FILL if en=1 at that edge, else IDLE.
  - Back-to-back words therefore have a one-cycle gap of sh_en=0.
- en=0 during FILL: the word in progress completes; no partial words are ever emitted. en is only checked in IDLE and at HOLD handshake.
- out_ready outside HOLD is ignored.
- reseed has priority in any state:
  - At that edge: state<=RESEED, counter<=0, sreg<=0, out_valid<=0.
  - RESEED lasts exactly one cycle (lfsr_load=1, sh_en=0), then IDLE.
  - FILL follows one cycle later if en=1.
  - reseed in RESEED simply extends it by one cycle.
  - out_data keeps its last value.
- reseed coinciding with out_valid & out_ready: the transfer counts as completed (consumer sampled out_data), then RESEED.
- rst_n asserted mid-FILL or mid-HOLD: immediate return to reset values; any partial or pending word is lost.

Optional Feature:
- Macro: LFSR_WORD_CTRL_STATS_EN.
- Defined: adds output port word_cnt [15:0].
  - Increments on each completed out_valid & out_ready transfer.
  - Wraps 0xFFFF -> 0x0000.
  - Cleared only by rst_n, not by reseed.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
All scenarios use the 17-bit LFSR with seed 17'h082F1 wired to sh_en/lfsr_bit, and lfsr_load driving LFSR reload.
- Default parameters, en=1, out_ready=1 -> first word 0x82 at cycle 9 after en sampled, second word 0xF1. sh_en high 8 cycles, low 1, high 8.
- SKIP=8, en=1 -> first word 0xF1; sh_en high 16 cycles before out_valid.
- out_ready held 0 for 20 cycles in HOLD -> out_valid=1, out_data=0x82 stable, sh_en=0 throughout. Ready=1 -> valid drops next cycle and FILL resumes.
- en dropped at 3rd FILL cycle -> word 0x82 still completes. After handshake state IDLE, sh_en stays 0.
- reseed pulse at 5th FILL cycle -> one-cycle lfsr_load, no word emitted. With en=1, the next word is 0x82 again.
- rst_n pulsed low mid-HOLD -> all outputs 0 immediately. With LFSR_WORD_CTRL_STATS_EN defined, word_cnt counts 3 handshakes, keeps 3 across reseed, and reads 0 after reset.

Source files
------------

// File: rtl/lfsr_word_ctrl.sv
// lfsr_word_ctrl: sequences a 17-bit serial LFSR and packs its bits into WORD_W-bit handshaked words.
// Optional 16-bit transfer counter (word_cnt) when LFSR_WORD_CTRL_STATS_EN is defined.
module lfsr_word_ctrl #(
    parameter int WORD_W = 8,
    parameter int SKIP   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              reseed,
    input  logic              lfsr_bit,
    output logic              sh_en,
    output logic              lfsr_load,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef LFSR_WORD_CTRL_STATS_EN
    output logic [15:0]       word_cnt,
`endif
    output logic              busy
);
    localparam int TOTAL = SKIP + WORD_W;
    localparam int CW    = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {IDLE, FILL, HOLD, RESEED} state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [WORD_W-1:0] sreg_q, sreg_d, data_q;
    logic              valid_q, keep, last;

    assign sreg_d    = (sreg_q << 1) | WORD_W'(lfsr_bit);
    assign last      = cnt_q == CW'(TOTAL - 1);
    assign sh_en     = state_q == FILL;
    assign lfsr_load = state_q == RESEED;
    assign busy      = sh_en | lfsr_load;
    assign out_data  = data_q;
    assign out_valid = valid_q;

    // The first SKIP shifts of every word are thrown away.
    if (SKIP == 0) begin : g_noskip
        assign keep = 1'b1;
    end else begin : g_skip
        assign keep = cnt_q >= CW'(SKIP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sreg_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (reseed) begin
            state_q <= RESEED;
            cnt_q   <= '0;
            sreg_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (en) state_q <= FILL;
                FILL: begin
                    if (keep) sreg_q <= sreg_d;
                    if (last) begin
                        data_q  <= sreg_d;
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOLD: if (out_ready) begin
                    valid_q <= 1'b0;
                    state_q <= en ? FILL : IDLE;
                end
                RESEED: state_q <= IDLE;
            endcase
        end
    end

`ifdef LFSR_WORD_CTRL_STATS_EN
    logic [15:0] word_cnt_q;

    assign word_cnt = word_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) word_cnt_q <= '0;
        else if (valid_q && out_ready) word_cnt_q <= word_cnt_q + 16'd1;
    end
`endif

endmodule
